ga23_sdr_arbiter: RTL and testbench
===================================

# ga23_sdr_arbiter

Shares the single graphics-ROM SDRAM read channel among the GA23 tile-layer fetch units. Each layer issues one-cycle `sdr_req` pulses with a 22-bit word address and waits for a 32-bit row; the arbiter latches these requests, serves them one at a time in round-robin order, and returns each row with a one-cycle ready pulse to the requesting layer. It sits between the layer instances and the SDRAM controller's graphics port.

## Interface
- `NUM_LAYERS`, 3, number of requesting layer units (2..4)
- `ADDR_W`, 22, SDRAM word address width
- `clk` in 1: system clock, all logic rising-edge
- `reset_n` in 1: asynchronous active-low reset
- `layer_req` in NUM_LAYERS: per-layer one-cycle request pulse
- `layer_addr` in NUM_LAYERS×ADDR_W: per-layer address, valid when the matching `layer_req` bit is high
- `layer_data` out NUM_LAYERS×32: per-layer returned row, held until that layer's next completion
- `layer_rdy` out NUM_LAYERS: per-layer one-cycle completion pulse
- `ram_addr` out ADDR_W: address to the SDRAM controller
- `ram_req` out 1: one-cycle request pulse to the SDRAM controller
- `ram_ack` in 1: one-cycle completion from the controller; `ram_data` is valid in the same cycle
- `ram_data` in 32: returned row
- `busy` out 1: high when state is not IDLE or any request is pending

## Operation
- Per layer: `pend[i]` flag and `pend_addr[i]` register. A `layer_req[i]` pulse sets `pend[i]` and loads `pend_addr[i]`. A request for a layer that is already pending overwrites its address; the latest request wins and only one completion is returned.
- State machine:
  - IDLE: if any `pend` is set, pick winner `g` round-robin, searching from `last+1` and wrapping modulo NUM_LAYERS. Register `ram_addr <= pend_addr[g]`, pulse `ram_req`, clear `pend[g]` unless `layer_req[g]` is high in the same cycle (the new request stays pending), set `cur <= g`, `last <= g`, go to WAIT.
  - WAIT: on `ram_ack`, register `layer_data[cur] <= ram_data`, pulse `layer_rdy[cur]`, go to IDLE.
- New `layer_req` from any layer, including `cur`, during WAIT is latched as pending and served afterwards. It never cancels the in-flight access.
- `ram_ack` in IDLE is ignored; it is a stale acknowledge, for example after reset mid-access.
- At most one outstanding SDRAM access at any time.

## Timing
- Reset values: `ram_req` 0, `ram_addr` 0, `layer_rdy` 0, `layer_data` 0, all `pend` 0, state IDLE, `last` = NUM_LAYERS-1 so that layer 0 is served first, `cur` 0, `busy` 0.
- `layer_req[i]` at cycle N with the arbiter idle and no other pending request: `ram_req` high at N+1 with `ram_addr` = that address.
- `ram_ack` at cycle M: `layer_rdy[cur]` high at M+1 with `layer_data` valid. The next `ram_req` is issued at M+2 at the earliest.
- Round-robin fairness: with all layers continuously pending, grants rotate 0,1,2,0,… and no layer waits more than NUM_LAYERS-1 other accesses.
- `reset_n` asserted mid-access: everything returns to reset values immediately. The following `ram_ack` is dropped because the state is IDLE.
- `ram_req` and `layer_rdy` are each high for exactly one cycle per access.

## Structure
- Shared package `ga23_pkg`:
  - `GA23_SDR_ADDR_W` = 22
  - `GA23_NUM_LAYERS` = 3
  - `typedef logic [21:0] ga23_sdr_addr_t`
  - state enum `ga23_arb_state_t {ARB_IDLE, ARB_WAIT}`
- One combinational sub-module, `ga23_rr_picker`:
  - inputs: pending vector and `last`
  - outputs: `valid` and winner index
  - reusable by the sprite fetch path.

## Test plan
- Single request: pulse `layer_req[1]` with address 0x12345 at N → `ram_req` at N+1 with `ram_addr`=0x12345. Ack 5 cycles later with 0xDEADBEEF → `layer_rdy[1]` one cycle later and `layer_data[1]`=0xDEADBEEF; no other `layer_rdy` bit fires.
- Simultaneous requests: all three layers request in the same cycle after reset → served in order 0,1,2, each getting its own address and data. The second round, started with all pending and `last`=2, again serves 0,1,2.
- Overwrite while pending: layer 2 requests 0x100 then 0x200 while layer 0 is in flight → exactly one access for layer 2, with address 0x200.
- Request during own access: layer 0 requests again during its WAIT → after ack, a second `ram_req` for layer 0 issues at M+2.
- Reset mid-access: `reset_n` low during WAIT, then a `ram_ack` → no `layer_rdy`, `busy`=0, all outputs at reset values.
- Stress: random requests with random ack latency 1–20 cycles over 10k cycles → scoreboard shows every final request completed, data matches a model memory, and no layer starves beyond 2 intervening grants.

Source files
------------

// File: rtl/ga23_pkg.sv
// Shared GA23 graphics-ROM definitions: address width, layer count, arbiter state.
package ga23_pkg;
  localparam int GA23_SDR_ADDR_W = 22;
  localparam int GA23_NUM_LAYERS = 3;

  typedef logic [GA23_SDR_ADDR_W-1:0] ga23_sdr_addr_t;

  typedef enum logic {ARB_IDLE, ARB_WAIT} ga23_arb_state_t;

  function automatic int ga23_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ga23_rr_picker.sv
// Round-robin picker: first set bit of pend searching from last+1, wrapping mod N.
import ga23_pkg::*;

module ga23_rr_picker #(
  parameter int N     = GA23_NUM_LAYERS,
  parameter int IDX_W = ga23_idx_w(GA23_NUM_LAYERS)
) (
  input  logic [N-1:0]     pend,
  input  logic [IDX_W-1:0] last,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    // Walk from the farthest candidate back so the one nearest last+1 wins.
    for (int k = N; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % N);
      if (pend[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/ga23_sdr_arbiter.sv
// Shares the graphics-ROM SDRAM read port among the tile layers, one access at a time,
// round-robin, with per-layer latched requests.
import ga23_pkg::*;

module ga23_sdr_arbiter #(
  parameter int NUM_LAYERS = GA23_NUM_LAYERS,
  parameter int ADDR_W     = GA23_SDR_ADDR_W
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_LAYERS-1:0]               layer_req,
  input  logic [NUM_LAYERS-1:0][ADDR_W-1:0]   layer_addr,
  output logic [NUM_LAYERS-1:0][31:0]         layer_data,
  output logic [NUM_LAYERS-1:0]               layer_rdy,
  output logic [ADDR_W-1:0]                   ram_addr,
  output logic                                ram_req,
  input  logic                                ram_ack,
  input  logic [31:0]                         ram_data,
  output logic                                busy
);
  localparam int IDX_W = ga23_idx_w(NUM_LAYERS);

  ga23_arb_state_t                  state, nxt_state;
  logic [NUM_LAYERS-1:0]            pend;
  logic [NUM_LAYERS-1:0][ADDR_W-1:0] pend_addr;
  logic [IDX_W-1:0]                 last, cur;
  logic                             pick_valid;
  logic [IDX_W-1:0]                 pick_idx;
  logic                             issue, complete;

  // Fresh requests are visible to the picker in their own cycle so an idle
  // arbiter issues the access on the very next edge.
  ga23_rr_picker #(.N(NUM_LAYERS), .IDX_W(IDX_W)) u_picker (
    .pend  (pend | layer_req),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ARB_IDLE;
    else          state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      ARB_IDLE: if (pick_valid) nxt_state = ARB_WAIT;
      ARB_WAIT: if (ram_ack)    nxt_state = ARB_IDLE;
      default:                  nxt_state = ARB_IDLE;
    endcase
  end

  always_comb begin
    issue    = (state == ARB_IDLE) && pick_valid;
    complete = (state == ARB_WAIT) && ram_ack;
  end

  assign busy = (state != ARB_IDLE) || (|pend);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_req   <= 1'b0;
      ram_addr  <= '0;
      cur       <= '0;
      last      <= IDX_W'(NUM_LAYERS - 1);
      layer_rdy <= '0;
    end else begin
      ram_req   <= issue;
      layer_rdy <= '0;
      if (issue) begin
        // A latched request is served before a same-cycle one from that layer.
        ram_addr <= pend[pick_idx] ? pend_addr[pick_idx] : layer_addr[pick_idx];
        cur      <= pick_idx;
        last     <= pick_idx;
      end
      if (complete) layer_rdy[cur] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend       <= '0;
      pend_addr  <= '0;
      layer_data <= '0;
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (issue && pick_idx == IDX_W'(i)) pend[i] <= pend[i] & layer_req[i];
        else if (layer_req[i])              pend[i] <= 1'b1;
        if (layer_req[i]) pend_addr[i] <= layer_addr[i];
        if (complete && cur == IDX_W'(i)) layer_data[i] <= ram_data;
      end
    end
  end
endmodule

// File: tb/tb_ga23_sdr_arbiter.sv
// Bench for ga23_sdr_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_ga23_sdr_arbiter;
  logic              clk = 1'b0;
  logic              reset_n;
  logic [2:0]        layer_req;
  logic [2:0][21:0]  layer_addr;
  logic [2:0][31:0]  layer_data;
  logic [2:0]        layer_rdy;
  logic [21:0]       ram_addr;
  logic              ram_req;
  logic              ram_ack;
  logic [31:0]       ram_data;
  logic              busy;

  int errors = 0;
  int checks = 0;

  typedef struct {int cyc; logic [21:0] addr;} req_t;
  req_t q[3][$];

  ga23_sdr_arbiter #(.NUM_LAYERS(3), .ADDR_W(22)) dut (
    .clk(clk), .reset_n(reset_n), .layer_req(layer_req), .layer_addr(layer_addr),
    .layer_data(layer_data), .layer_rdy(layer_rdy), .ram_addr(ram_addr), .ram_req(ram_req),
    .ram_ack(ram_ack), .ram_data(ram_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] mem_f(input logic [21:0] a);
    return {a[9:0], a} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; layer_req = 3'b111; layer_addr = '0; ram_ack = 1'b0; ram_data = '0;
    tick(); tick();
    checks++; if (ram_req !== 1'b0) begin errors++; $display("FAIL reset_ram_req got=%b exp=0", ram_req); end
    checks++; if (ram_addr !== 22'h0) begin errors++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
    checks++; if (layer_rdy !== 3'b000) begin errors++; $display("FAIL reset_layer_rdy got=%b exp=000", layer_rdy); end
    checks++; if (layer_data !== '0) begin errors++; $display("FAIL reset_layer_data got=%h exp=0", layer_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    layer_req = 3'b000;
    reset_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || ram_req !== 1'b0) begin errors++; $display("FAIL reset_release got busy=%b req=%b exp 0 0", busy, ram_req); end
  endtask

  task automatic test_single();
    layer_req = 3'b010; layer_addr[1] = 22'h12345;
    tick();
    layer_req = 3'b000;
    checks++; if (ram_req !== 1'b1 || ram_addr !== 22'h12345) begin errors++; $display("FAIL single_issue got req=%b addr=%h exp 1 12345", ram_req, ram_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (ram_req !== 1'b0 || layer_rdy !== 3'b000) begin errors++; $display("FAIL single_wait got req=%b rdy=%b exp 0 000", ram_req, layer_rdy); end
    end
    ram_ack = 1'b1; ram_data = 32'hDEADBEEF;
    tick();
    ram_ack = 1'b0; ram_data = 32'h0;
    checks++; if (layer_rdy !== 3'b010) begin errors++; $display("FAIL single_rdy got=%b exp=010", layer_rdy); end
    checks++; if (layer_data[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got=%h exp=deadbeef", layer_data[1]); end
    tick();
    checks++; if (layer_rdy !== 3'b000 || busy !== 1'b0 || layer_data[1] !== 32'hDEADBEEF)
      begin errors++; $display("FAIL single_after got rdy=%b busy=%b data=%h exp 000 0 deadbeef", layer_rdy, busy, layer_data[1]); end
  endtask

  task automatic test_simultaneous();
    logic [21:0] a[6];
    logic [31:0] d[6];
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      a[k] = 22'h3000 + 22'(k * 17);
      d[k] = 32'hA0000000 + 32'(k * 3);
    end
    layer_req = 3'b111;
    for (int i = 0; i < 3; i++) layer_addr[i] = a[i];
    tick();
    layer_req = 3'b000;
    for (int k = 0; k < 6; k++) begin
      checks++; if (ram_req !== 1'b1 || ram_addr !== a[k]) begin errors++; $display("FAIL simul_issue%0d got req=%b addr=%h exp 1 %h", k, ram_req, ram_addr, a[k]); end
      if (k == 2) begin
        layer_req = 3'b111;
        for (int i = 0; i < 3; i++) layer_addr[i] = a[3 + i];
      end
      ram_ack = 1'b1; ram_data = d[k];
      tick();
      ram_ack = 1'b0; layer_req = 3'b000;
      checks++; if (layer_rdy !== 3'(1 << (k % 3)) || layer_data[k % 3] !== d[k] || ram_req !== 1'b0)
        begin errors++; $display("FAIL simul_rdy%0d got rdy=%b data=%h req=%b exp %b %h 0", k, layer_rdy, layer_data[k % 3], ram_req, 3'(1 << (k % 3)), d[k]); end
      tick();
    end
    checks++; if (busy !== 1'b0 || ram_req !== 1'b0) begin errors++; $display("FAIL simul_idle got busy=%b req=%b exp 0 0", busy, ram_req); end
  endtask

  task automatic test_overwrite();
    int n_req;
    layer_req = 3'b001; layer_addr[0] = 22'h40;
    tick();
    layer_req = 3'b100; layer_addr[2] = 22'h100;
    checks++; if (ram_req !== 1'b1 || ram_addr !== 22'h40) begin errors++; $display("FAIL ovw_first got req=%b addr=%h exp 1 40", ram_req, ram_addr); end
    tick();
    layer_addr[2] = 22'h200;
    tick();
    layer_req = 3'b000;
    tick();
    ram_ack = 1'b1; ram_data = 32'h1111_0000;
    tick();
    ram_ack = 1'b0;
    checks++; if (layer_rdy !== 3'b001) begin errors++; $display("FAIL ovw_rdy0 got=%b exp=001", layer_rdy); end
    tick();
    checks++; if (ram_req !== 1'b1 || ram_addr !== 22'h200) begin errors++; $display("FAIL ovw_second got req=%b addr=%h exp 1 200", ram_req, ram_addr); end
    ram_ack = 1'b1; ram_data = 32'h2222_0000;
    tick();
    ram_ack = 1'b0;
    checks++; if (layer_rdy !== 3'b100 || layer_data[2] !== 32'h2222_0000) begin errors++; $display("FAIL ovw_rdy2 got rdy=%b data=%h exp 100 22220000", layer_rdy, layer_data[2]); end
    n_req = 0;
    for (int k = 0; k < 5; k++) begin tick(); if (ram_req === 1'b1) n_req++; end
    checks++; if (n_req != 0 || busy !== 1'b0) begin errors++; $display("FAIL ovw_extra got reqs=%0d busy=%b exp 0 0", n_req, busy); end
  endtask

  task automatic test_own_request();
    layer_req = 3'b001; layer_addr[0] = 22'h55;
    tick();
    checks++; if (ram_req !== 1'b1 || ram_addr !== 22'h55) begin errors++; $display("FAIL own_first got req=%b addr=%h exp 1 55", ram_req, ram_addr); end
    layer_addr[0] = 22'h66;
    tick();
    layer_req = 3'b000;
    tick();
    ram_ack = 1'b1; ram_data = 32'h0000_5555;
    tick();
    ram_ack = 1'b0;
    checks++; if (layer_rdy !== 3'b001 || ram_req !== 1'b0) begin errors++; $display("FAIL own_rdy got rdy=%b req=%b exp 001 0", layer_rdy, ram_req); end
    tick();
    checks++; if (ram_req !== 1'b1 || ram_addr !== 22'h66) begin errors++; $display("FAIL own_second got req=%b addr=%h exp 1 66", ram_req, ram_addr); end
    ram_ack = 1'b1; ram_data = 32'h0000_6666;
    tick();
    ram_ack = 1'b0;
    checks++; if (layer_rdy !== 3'b001 || layer_data[0] !== 32'h0000_6666) begin errors++; $display("FAIL own_rdy2 got rdy=%b data=%h exp 001 00006666", layer_rdy, layer_data[0]); end
    tick();
  endtask

  task automatic test_reset_mid_access();
    layer_req = 3'b010; layer_addr[1] = 22'h777;
    tick();
    layer_req = 3'b100; layer_addr[2] = 22'h888;
    checks++; if (ram_req !== 1'b1 || ram_addr !== 22'h777) begin errors++; $display("FAIL rstmid_issue got req=%b addr=%h exp 1 777", ram_req, ram_addr); end
    tick();
    layer_req = 3'b000;
    reset_n = 1'b0;
    #1;
    checks++; if (ram_addr !== 22'h0 || layer_data !== '0 || busy !== 1'b0 || layer_rdy !== 3'b000)
      begin errors++; $display("FAIL rstmid_async got addr=%h data=%h busy=%b rdy=%b exp all 0", ram_addr, layer_data, busy, layer_rdy); end
    tick();
    reset_n = 1'b1;
    ram_ack = 1'b1; ram_data = 32'hBAD0BAD0;
    tick();
    ram_ack = 1'b0;
    checks++; if (layer_rdy !== 3'b000 || busy !== 1'b0 || layer_data !== '0 || ram_req !== 1'b0)
      begin errors++; $display("FAIL rstmid_stale_ack got rdy=%b busy=%b data=%h req=%b exp all 0", layer_rdy, busy, layer_data, ram_req); end
    tick();
    checks++; if (layer_rdy !== 3'b000 || ram_req !== 1'b0) begin errors++; $display("FAIL rstmid_after got rdy=%b req=%b exp 000 0", layer_rdy, ram_req); end
  endtask

  task automatic test_stress();
    int last_m, out_l, cnt, rdy_l, ackp, w;
    int wait_g[3];
    bit outst, rdy_exp, any_q, older;
    logic [21:0] out_a, exp_a;
    logic [31:0] exp_d, rdy_d, r;
    req_t keep[$];
    pulse_reset();
    for (int i = 0; i < 3; i++) begin q[i].delete(); wait_g[i] = 0; end
    last_m = 2; outst = 0; rdy_exp = 0; out_l = 0; cnt = 0; rdy_l = 0; ackp = -10;
    out_a = '0; exp_d = '0; rdy_d = '0;
    layer_req = 3'b000; ram_ack = 1'b0;
    for (int c = 0; c < 10200; c++) begin
      tick();
      if (ram_req === 1'b1) begin
        w = -1;
        for (int k = 1; k <= 3; k++) begin
          int j;
          j = (last_m + k) % 3;
          if (w < 0 && q[j].size() > 0) w = j;
        end
        checks++;
        if (outst || c < ackp + 2 || w < 0) begin
          errors++; $display("FAIL stress_issue_legal c=%0d got req=1 outstanding=%0b ack_at=%0d winner=%0d", c, outst, ackp, w);
        end else begin
          older = 0; exp_a = '0; keep.delete();
          foreach (q[w][n]) begin
            if (q[w][n].cyc < c - 1) begin older = 1; exp_a = q[w][n].addr; end
            else keep.push_back(q[w][n]);
          end
          if (!older) begin exp_a = q[w][0].addr; keep.delete(); end
          q[w] = keep;
          checks++; if (ram_addr !== exp_a) begin errors++; $display("FAIL stress_grant c=%0d got addr=%h exp=%h (layer %0d)", c, ram_addr, exp_a, w); end
          for (int j = 0; j < 3; j++) if (j != w && q[j].size() > 0) wait_g[j]++;
          wait_g[w] = 0;
          for (int j = 0; j < 3; j++) begin
            checks++; if (wait_g[j] > 2) begin errors++; $display("FAIL stress_starve layer=%0d got waits=%0d exp<=2", j, wait_g[j]); end
          end
          last_m = w; outst = 1; out_l = w; out_a = ram_addr; exp_d = mem_f(exp_a);
          cnt = int'($urandom_range(1, 20));
        end
      end
      checks++;
      if (rdy_exp) begin
        if (layer_rdy !== 3'(1 << rdy_l) || layer_data[rdy_l] !== rdy_d) begin
          errors++; $display("FAIL stress_rdy c=%0d got rdy=%b data=%h exp %b %h", c, layer_rdy, layer_data[rdy_l], 3'(1 << rdy_l), rdy_d);
        end
      end else if (layer_rdy !== 3'b000) begin
        errors++; $display("FAIL stress_rdy_spurious c=%0d got rdy=%b exp=000", c, layer_rdy);
      end
      rdy_exp = 0;
      any_q = 0;
      for (int j = 0; j < 3; j++) if (q[j].size() > 0) any_q = 1;
      checks++; if (busy !== (outst | any_q)) begin errors++; $display("FAIL stress_busy c=%0d got=%b exp=%b", c, busy, outst | any_q); end
      ram_ack = 1'b0; ram_data = $urandom;
      if (outst) begin
        cnt--;
        if (cnt == 0) begin
          ram_ack = 1'b1; ram_data = mem_f(out_a);
          outst = 0; rdy_exp = 1; rdy_l = out_l; rdy_d = exp_d; ackp = c;
        end
      end
      layer_req = 3'b000;
      for (int i = 0; i < 3; i++) begin
        r = $urandom;
        layer_addr[i] = {r[19:0], 2'(i)};
        if (c < 10000 && $urandom_range(0, 7) == 0) begin
          layer_req[i] = 1'b1;
          if (q[i].size() == 0) wait_g[i] = 0;
          q[i].push_back('{c, layer_addr[i]});
        end
      end
    end
    any_q = 0;
    for (int j = 0; j < 3; j++) if (q[j].size() > 0) any_q = 1;
    checks++; if (any_q || outst || busy !== 1'b0) begin errors++; $display("FAIL stress_drain got pending=%0b outstanding=%0b busy=%b exp 0 0 0", any_q, outst, busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_overwrite();
    test_own_request();
    test_reset_mid_access();
    test_stress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
